axis_lrelu_config_injector: RTL and testbench

//  Transmit side of the LReLU engine input stream. Merges the per-iteration config stream and the conv-core output stream into one AXIS stream.

---
 rtl/axis_lrelu_config_injector_pkg.sv | 37 +++
 rtl/axis_lrelu_config_injector_if.sv | 21 ++
 rtl/axis_skid_buffer.sv | 56 +++++
 rtl/axis_lrelu_config_injector.sv | 125 ++++++++++++
 tb/tb_axis_lrelu_config_injector.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_lrelu_config_injector_pkg.sv
`default_nettype none
// ============================================================================
// Module : axis_lrelu_config_injector_pkg
// Brief  : Shared widths, config beat counts and FSM encoding for the injector.
// Rev    : 1.0
// ============================================================================
package axis_lrelu_config_injector_pkg;

   localparam int WORD_WIDTH_ACC     = 32;
   localparam int UNITS              = 8;
   localparam int GROUPS             = 2;
   localparam int COPIES             = 2;
   localparam int MEMBERS            = 12;
   localparam int TUSER_WIDTH        = 8;
   localparam int I_IS_1X1           = 0;
   localparam int BEATS_CONFIG_3X3_1 = 9;
   localparam int BEATS_CONFIG_1X1_1 = 5;

   localparam int W          = COPIES * GROUPS * MEMBERS * UNITS * WORD_WIDTH_ACC;
   localparam int K          = W / 8;
   localparam int U          = MEMBERS * TUSER_WIDTH;
   localparam int SKID_WIDTH = W + K + U + 1;
   localparam int CNT_WIDTH  = 4;

   typedef enum logic [0:0] {
      CFG_S  = 1'b0,
      DATA_S = 1'b1
   } state_t;

   // Counter preload on the first config beat; the last beat is seen at zero.
   function automatic logic [CNT_WIDTH-1:0] cfg_count_init(input logic is1x1);
      return is1x1 ? CNT_WIDTH'(BEATS_CONFIG_1X1_1 - 2)
                   : CNT_WIDTH'(BEATS_CONFIG_3X3_1 - 2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_lrelu_config_injector_if.sv
`default_nettype none
// ============================================================================
// Module : axis_lrelu_config_injector_if
// Brief  : AXI-Stream bundle (data/keep/user/last) with master/slave views.
// Rev    : 1.0
// ============================================================================
interface axis_lrelu_config_injector_if;
   import axis_lrelu_config_injector_pkg::*;

   logic         tvalid;
   logic         tready;
   logic [W-1:0] tdata;
   logic [K-1:0] tkeep;
   logic [U-1:0] tuser;
   logic         tlast;

   modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
   modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module : axis_skid_buffer
// Brief  : Two-entry registered ready/valid buffer; ready depends only on fill.
// Rev    : 1.0
// ============================================================================
module axis_skid_buffer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [1:0]            fill;
   logic [1:0]            fill_after_pop;
   logic [DATA_WIDTH-1:0] slot0;
   logic [DATA_WIDTH-1:0] slot1;
   logic                  push;
   logic                  pop;

   assign in_ready       = (fill != 2'd2);
   assign out_valid      = (fill != 2'd0);
   assign out_data       = slot0;
   assign push           = in_valid && in_ready;
   assign pop            = out_valid && out_ready;
   assign fill_after_pop = fill - {1'b0, pop};

   // slot0 is always the head; a push lands in the first free slot after the pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill  <= 2'd0;
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         fill <= fill_after_pop + {1'b0, push};
         if (pop) begin
            slot0 <= slot1;
         end
         if (push) begin
            if (fill_after_pop == 2'd0) begin
               slot0 <= in_data;
            end else begin
               slot1 <= in_data;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/axis_lrelu_config_injector.sv
`default_nettype none
// ============================================================================
// Module : axis_lrelu_config_injector
// Brief  : Merges per-iteration config beats and conv data into one AXIS stream.
// Rev    : 1.0
// ============================================================================
module axis_lrelu_config_injector
   import axis_lrelu_config_injector_pkg::*;
(
   input  logic                          aclk,
   input  logic                          areset,
   axis_lrelu_config_injector_if.slave   s_conv,
   axis_lrelu_config_injector_if.slave   s_cfg,
   axis_lrelu_config_injector_if.master  m_axis,
   output logic                          err_cfg,
   output logic                          debug_state,
   output logic [15:0]                   debug_iter
);

   state_t                 state;
   state_t                 state_next;
   logic [CNT_WIDTH-1:0]   count;
   logic                   first;
   logic                   is1x1;
   logic                   skid_rdy;
   logic                   skid_valid;
   logic [SKID_WIDTH-1:0]  skid_in;
   logic [SKID_WIDTH-1:0]  skid_out;
   logic                   cfg_hs;
   logic                   conv_hs;
   logic                   cfg_last;
   logic [U-1:0]           cfg_user;

   assign cfg_hs      = (state == CFG_S)  && skid_rdy && s_cfg.tvalid;
   assign conv_hs     = (state == DATA_S) && skid_rdy && s_conv.tvalid;
   assign cfg_last    = !first && (count == '0);
   assign debug_state = (state == DATA_S);

   // The first beat carries the live flag; later beats repeat the latched one.
   always_comb begin
      cfg_user           = s_cfg.tuser;
      cfg_user[I_IS_1X1] = first ? s_cfg.tuser[I_IS_1X1] : is1x1;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state <= CFG_S;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      s_cfg.tready = 1'b0;
      s_conv.tready = 1'b0;
      skid_valid   = 1'b0;
      skid_in      = '0;
      unique case (state)
         CFG_S: begin
            s_cfg.tready = skid_rdy;
            skid_valid   = s_cfg.tvalid;
            skid_in      = {1'b0, cfg_user, {K{1'b1}}, s_cfg.tdata};
            if (cfg_hs && cfg_last) begin
               state_next = DATA_S;
            end
         end
         DATA_S: begin
            s_conv.tready = skid_rdy;
            skid_valid    = s_conv.tvalid;
            skid_in       = {s_conv.tlast, s_conv.tuser, s_conv.tkeep, s_conv.tdata};
            if (conv_hs && s_conv.tlast) begin
               state_next = CFG_S;
            end
         end
         default: ;
      endcase
   end

   // Framing follows the counter; s_cfg_tlast is only cross-checked.
   always_ff @(posedge aclk) begin
      if (areset) begin
         count      <= '0;
         first      <= 1'b1;
         is1x1      <= 1'b0;
         err_cfg    <= 1'b0;
         debug_iter <= '0;
      end else begin
         if (cfg_hs) begin
            if (first) begin
               is1x1 <= s_cfg.tuser[I_IS_1X1];
               count <= cfg_count_init(s_cfg.tuser[I_IS_1X1]);
               first <= 1'b0;
            end else if (count == '0) begin
               first <= 1'b1;
            end else begin
               count <= count - 1'b1;
            end
            if (s_cfg.tlast != cfg_last) begin
               err_cfg <= 1'b1;
            end
         end
         if (conv_hs && s_conv.tlast) begin
            debug_iter <= debug_iter + 16'd1;
         end
      end
   end

   axis_skid_buffer #(
      .DATA_WIDTH (SKID_WIDTH)
   ) u_skid (
      .clk       (aclk),
      .rst       (areset),
      .in_valid  (skid_valid),
      .in_ready  (skid_rdy),
      .in_data   (skid_in),
      .out_valid (m_axis.tvalid),
      .out_ready (m_axis.tready),
      .out_data  (skid_out)
   );

   assign {m_axis.tlast, m_axis.tuser, m_axis.tkeep, m_axis.tdata} = skid_out;

endmodule
`default_nettype wire

// File: tb/tb_axis_lrelu_config_injector.sv
`default_nettype none
// ============================================================================
// Module : tb_axis_lrelu_config_injector
// Brief  : Scoreboard bench for the config/conv stream merger.
// Rev    : 1.0
// ============================================================================
module tb_axis_lrelu_config_injector;
   import axis_lrelu_config_injector_pkg::*;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        err_cfg;
   logic        debug_state;
   logic [15:0] debug_iter;

   always #5 aclk = ~aclk;

   axis_lrelu_config_injector_if s_conv ();
   axis_lrelu_config_injector_if s_cfg ();
   axis_lrelu_config_injector_if m_axis ();

   axis_lrelu_config_injector dut (
      .aclk        (aclk),
      .areset      (areset),
      .s_conv      (s_conv),
      .s_cfg       (s_cfg),
      .m_axis      (m_axis),
      .err_cfg     (err_cfg),
      .debug_state (debug_state),
      .debug_iter  (debug_iter)
   );

   typedef struct {
      logic [W-1:0] data;
      logic [K-1:0] keep;
      logic [U-1:0] user;
      logic         last;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    cyc = 0;
   int    out_cnt = 0;
   int    last_cnt = 0;
   int    first_out_cyc = -1;
   int    last_out_cyc = 0;
   int    cfg_done = 0;
   bit    rand_ready = 1'b0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] fold(input logic [W-1:0] v);
      logic [63:0] f = '0;
      for (int i = 0; i < W / 64; i++) f ^= v[i*64 +: 64];
      return f;
   endfunction

   function automatic logic [W-1:0] rand_wide();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   initial begin : ready_driver
      m_axis.tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         m_axis.tready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      end
   end

   initial begin : monitor
      bit    stall;
      beat_t held;
      beat_t e;
      stall = 1'b0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               check("stable_valid", m_axis.tvalid, 1);
               check("stable_data", fold(m_axis.tdata), fold(held.data));
               check("stable_last", m_axis.tlast, held.last);
            end
            if (m_axis.tvalid && m_axis.tready) begin
               out_cnt++;
               if (first_out_cyc < 0) first_out_cyc = cyc;
               last_out_cyc = cyc;
               if (m_axis.tlast) last_cnt++;
               check("beat_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("tdata", fold(m_axis.tdata), fold(e.data));
                  check("tkeep", fold(W'(m_axis.tkeep)), fold(W'(e.keep)));
                  check("tuser", fold(W'(m_axis.tuser)), fold(W'(e.user)));
                  check("tlast", m_axis.tlast, e.last);
               end
               stall = 1'b0;
            end else if (m_axis.tvalid) begin
               stall     = 1'b1;
               held.data = m_axis.tdata;
               held.last = m_axis.tlast;
            end else begin
               stall = 1'b0;
            end
         end
      end
   end

   task automatic cfg_iter(input bit one, input int err_beat, input int gap_pct);
      int    n;
      bit    ok;
      beat_t e;
      n = one ? BEATS_CONFIG_1X1_1 : BEATS_CONFIG_3X3_1;
      cfg_done = 0;
      for (int b = 0; b < n; b++) begin
         for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
            s_cfg.tvalid = 1'b0;
            @(posedge aclk);
            #1;
         end
         s_cfg.tdata = rand_wide();
         s_cfg.tkeep = K'(rand_wide());
         s_cfg.tuser = U'(rand_wide());
         s_cfg.tuser[I_IS_1X1] = (b == 0) ? one : !one;
         s_cfg.tlast = (b == n - 1) || (err_beat == b + 1);
         s_cfg.tvalid = 1'b1;
         ok = 1'b0;
         for (int t = 0; t < 1000; t++) begin
            @(negedge aclk);
            if (s_cfg.tready) begin
               ok = 1'b1;
               break;
            end
         end
         check("cfg_accept", ok, 1);
         if (!ok) begin
            s_cfg.tvalid = 1'b0;
            return;
         end
         e.data = s_cfg.tdata;
         e.keep = '1;
         e.user = s_cfg.tuser;
         e.user[I_IS_1X1] = one;
         e.last = 1'b0;
         exp_q.push_back(e);
         cfg_done++;
         @(posedge aclk);
         #1;
      end
      s_cfg.tvalid = 1'b0;
   endtask

   task automatic conv_iter(input int n, input int n_cfg, input int gap_pct, input int abort_at);
      bit    ok;
      beat_t e;
      for (int b = 0; b < n; b++) begin
         for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
            s_conv.tvalid = 1'b0;
            @(posedge aclk);
            #1;
         end
         s_conv.tdata  = rand_wide();
         s_conv.tkeep  = K'(rand_wide());
         s_conv.tuser  = U'(rand_wide());
         s_conv.tlast  = (b == n - 1);
         s_conv.tvalid = 1'b1;
         if (b + 1 == abort_at) begin
            areset = 1'b1;
            @(posedge aclk);
            #1;
            check("abort_tvalid", m_axis.tvalid, 0);
            check("abort_state", debug_state, 0);
            check("abort_iter", debug_iter, 0);
            areset = 1'b0;
            s_conv.tvalid = 1'b0;
            exp_q.delete();
            return;
         end
         ok = 1'b0;
         for (int t = 0; t < 1000; t++) begin
            @(negedge aclk);
            if (s_conv.tready) begin
               ok = 1'b1;
               break;
            end
         end
         check("conv_accept", ok, 1);
         if (!ok) begin
            s_conv.tvalid = 1'b0;
            return;
         end
         if (b == 0) check("conv_after_cfg", cfg_done, n_cfg);
         e.data = s_conv.tdata;
         e.keep = s_conv.tkeep;
         e.user = s_conv.tuser;
         e.last = s_conv.tlast;
         exp_q.push_back(e);
         @(posedge aclk);
         #1;
      end
      s_conv.tvalid = 1'b0;
   endtask

   task automatic run_iter(input bit one, input int n_conv, input int err_beat, input int gap_pct);
      fork
         cfg_iter(one, err_beat, gap_pct);
         conv_iter(n_conv, one ? BEATS_CONFIG_1X1_1 : BEATS_CONFIG_3X3_1, gap_pct, 0);
      join
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 500; t++) begin
         @(posedge aclk);
         #2;
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain", ok, 1);
   endtask

   initial begin : main
      s_cfg.tvalid  = 1'b0;
      s_cfg.tdata   = '0;
      s_cfg.tkeep   = '0;
      s_cfg.tuser   = '0;
      s_cfg.tlast   = 1'b0;
      s_conv.tvalid = 1'b0;
      s_conv.tdata  = '0;
      s_conv.tkeep  = '0;
      s_conv.tuser  = '0;
      s_conv.tlast  = 1'b0;
      areset        = 1'b1;

      repeat (3) @(posedge aclk);
      #1;
      check("rst_m_tvalid", m_axis.tvalid, 0);
      check("rst_conv_tready", s_conv.tready, 0);
      check("rst_err", err_cfg, 0);
      check("rst_iter", debug_iter, 0);
      areset = 1'b0;
      @(posedge aclk);
      #1;
      check("post_rst_cfg_tready", s_cfg.tready, 1);
      check("post_rst_state", debug_state, 0);
      check("post_rst_m_tvalid", m_axis.tvalid, 0);
      check("post_rst_tdata", fold(m_axis.tdata), 0);
      check("post_rst_tlast", m_axis.tlast, 0);

      // Back-to-back 3x3 iteration at full rate.
      out_cnt = 0;
      last_cnt = 0;
      first_out_cyc = -1;
      run_iter(1'b0, 20, 0, 0);
      wait_drain();
      check("t2_beats", out_cnt, 29);
      check("t2_tlast_count", last_cnt, 1);
      check("t2_throughput", 64'(last_out_cyc - first_out_cyc), 28);
      check("t2_iter", debug_iter, 1);
      check("t2_err", err_cfg, 0);

      run_iter(1'b1, 4, 0, 0);
      wait_drain();
      check("t3_iter", debug_iter, 2);
      check("t3_err", err_cfg, 0);

      rand_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         run_iter(1'($urandom_range(1)), $urandom_range(1, 8), 0, 50);
      end
      wait_drain();
      rand_ready = 1'b0;
      check("t4_iter", debug_iter, 12);
      check("t4_err", err_cfg, 0);

      run_iter(1'b0, 3, 3, 0);
      wait_drain();
      check("t5_err", err_cfg, 1);
      check("t5_iter", debug_iter, 13);
      run_iter(1'b1, 2, 0, 0);
      wait_drain();
      check("t5_err_sticky", err_cfg, 1);
      check("t5_iter_after", debug_iter, 14);

      fork
         cfg_iter(1'b0, 0, 0);
         conv_iter(20, BEATS_CONFIG_3X3_1, 0, 7);
      join
      check("t6_err_cleared", err_cfg, 0);
      run_iter(1'b0, 20, 0, 0);
      wait_drain();
      check("t6_iter", debug_iter, 1);
      check("t6_err", err_cfg, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
